// File: rtl/i2c_target_regbank.sv
// i2c_target_regbank: I2C target (slave) with an NREGS x 8 register bank.
// The first written byte sets the register pointer. Later bytes write bank[ptr++].
// Reads return bank[ptr++]. A local host port reads and writes the same bank.
// SCL is only sampled, never stretched. SDA is driven open-drain through sda_oe.
module i2c_target_regbank #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         NREGS       = 8,
  parameter int         AW          = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_o,
  output logic          sda_oe,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic [7:0]    host_rdata,
  output logic          wr_valid,
  output logic [AW-1:0] wr_index,
  output logic [7:0]    wr_data,
  output logic          addressed
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  // [0],[1] form the synchronizer; [2] is the delayed copy used for edge detection.
  logic [2:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic       scl_s, scl_p, sda_s, sda_p;
  logic       scl_rise, scl_fall, bus_start, bus_stop;

  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          rw_q, rw_d;
  logic          first_byte_q, first_byte_d;
  logic          sda_oe_q, sda_oe_d;
  logic          addressed_q, addressed_d;
  logic          wr_valid_q, wr_valid_d;
  logic [AW-1:0] wr_index_q, wr_index_d;
  logic [7:0]    wr_data_q, wr_data_d;

  logic [7:0]    rx_byte, rd_byte;
  logic          i2c_we;
  logic [AW-1:0] i2c_idx;
  logic [7:0]    i2c_wdata;
  logic [7:0]    bank [NREGS];

  // Shift the pad inputs into the synchronizer chains.
  always_comb begin
    scl_sync_d = {scl_sync_q[1:0], scl_i};
    sda_sync_d = {sda_sync_q[1:0], sda_i};
  end

  // Synchronizer flops. They reset to the idle-high bus level so that no false edge appears.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign scl_p     = scl_sync_q[2];
  assign sda_s     = sda_sync_q[1];
  assign sda_p     = sda_sync_q[2];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign bus_start = scl_s & scl_p & sda_p & ~sda_s;
  assign bus_stop  = scl_s & scl_p & ~sda_p & sda_s;

  assign rx_byte = {shreg_q[6:0], sda_s};
  assign rd_byte = bank[ptr_q];

  // Protocol FSM: next state, shift register, pointer, SDA drive and I2C write request.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    ptr_d        = ptr_q;
    rw_d         = rw_q;
    first_byte_d = first_byte_q;
    sda_oe_d     = sda_oe_q;
    addressed_d  = addressed_q;
    wr_valid_d   = 1'b0;
    wr_index_d   = wr_index_q;
    wr_data_d    = wr_data_q;
    i2c_we       = 1'b0;
    i2c_idx      = ptr_q;
    i2c_wdata    = rx_byte;
    if (bus_stop) begin
      state_d     = IDLE;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
    end else if (bus_start) begin
      state_d     = ADDR;
      bit_cnt_d   = 4'd0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shreg_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shreg_q[7:1] == TARGET_ADDR) begin
              sda_oe_d    = 1'b1;
              addressed_d = 1'b1;
              rw_d        = shreg_q[0];
              state_d     = ADDR_ACK;
            end else begin
              state_d = IDLE;
            end
          end
        end
        ADDR_ACK, RD_ACK: begin
          if (state_q == RD_ACK && scl_rise && sda_s) begin
            // The controller NACKed the byte, so the read ends here.
            state_d     = IDLE;
            addressed_d = 1'b0;
            sda_oe_d    = 1'b0;
          end else if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (state_q == ADDR_ACK && !rw_q) begin
              sda_oe_d     = 1'b0;
              first_byte_d = 1'b1;
              state_d      = WR_DATA;
            end else begin
              // Capture the byte now, so that a later host write cannot change the byte in flight.
              shreg_d  = rd_byte;
              ptr_d    = ptr_q + AW'(1);
              sda_oe_d = ~rd_byte[7];
              state_d  = RD_DATA;
            end
          end
        end
        WR_DATA: begin
          if (scl_rise && bit_cnt_q != 4'd8) begin
            shreg_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (first_byte_q) begin
                ptr_d        = rx_byte[AW-1:0];
                first_byte_d = 1'b0;
              end else begin
                i2c_we     = 1'b1;
                wr_valid_d = 1'b1;
                wr_index_d = ptr_q;
                wr_data_d  = rx_byte;
                ptr_d      = ptr_q + AW'(1);
              end
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_oe_d  = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = WR_ACK;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = WR_DATA;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (bit_cnt_q != 4'd7) begin
              shreg_d   = {shreg_q[6:0], 1'b0};
              sda_oe_d  = ~shreg_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = RD_ACK;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM and output registers. An asynchronous reset releases SDA at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 4'd0;
      shreg_q      <= 8'h00;
      ptr_q        <= '0;
      rw_q         <= 1'b0;
      first_byte_q <= 1'b0;
      sda_oe_q     <= 1'b0;
      addressed_q  <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_index_q   <= '0;
      wr_data_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      ptr_q        <= ptr_d;
      rw_q         <= rw_d;
      first_byte_q <= first_byte_d;
      sda_oe_q     <= sda_oe_d;
      addressed_q  <= addressed_d;
      wr_valid_q   <= wr_valid_d;
      wr_index_q   <= wr_index_d;
      wr_data_q    <= wr_data_d;
    end
  end

  // Bank entries. An I2C write overrides a host write to the same index in the same cycle.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_bank
    logic [7:0] entry_q, entry_d;

    // Next value of this entry: host write first, then the I2C write on top.
    always_comb begin
      entry_d = entry_q;
      if (host_we && host_addr == AW'(gi)) entry_d = host_wdata;
      if (i2c_we && i2c_idx == AW'(gi))    entry_d = i2c_wdata;
    end

    // Entry storage. It clears to zero on reset.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) entry_q <= 8'h00;
      else         entry_q <= entry_d;
    end

    assign bank[gi] = entry_q;
  end

  assign sda_o      = 1'b0;
  assign sda_oe     = sda_oe_q;
  assign host_rdata = bank[host_addr];
  assign wr_valid   = wr_valid_q;
  assign wr_index   = wr_index_q;
  assign wr_data    = wr_data_q;
  assign addressed  = addressed_q;

endmodule
